// File: rtl/rx_input_port_pkg.sv
// Shared flit geometry, direction codes and intake FSM encoding for the router input stage.
// The macros are the project-wide constants; the package mirrors them as typed localparams.
`ifndef RX_INPUT_PORT_CONSTANTS
`define RX_INPUT_PORT_CONSTANTS
`define PAYLOAD_SIZE 8
`define ADDR_SZ 4
`define DIR_LOCAL 3'b001
`define DIR_EAST 3'b010
`define DIR_WEST 3'b100
`endif

package rx_input_port_pkg;

    localparam int ADDR_SZ      = `ADDR_SZ;
    localparam int PAYLOAD_SIZE = `PAYLOAD_SIZE;
    localparam int FLIT_W       = PAYLOAD_SIZE + ADDR_SZ;
    localparam int DIR_W        = 3;

    localparam logic [DIR_W-1:0] DIR_LOCAL = `DIR_LOCAL;
    localparam logic [DIR_W-1:0] DIR_EAST  = `DIR_EAST;
    localparam logic [DIR_W-1:0] DIR_WEST  = `DIR_WEST;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_DRAIN = 2'd2
    } intake_state_t;

    // Higher addresses lie to the east; equal address means the flit has arrived.
    function automatic logic [DIR_W-1:0] route(input logic [ADDR_SZ-1:0] dest,
                                               input logic [ADDR_SZ-1:0] here);
        logic [DIR_W-1:0] dir;
        if (dest == here) begin
            dir = DIR_LOCAL;
        end else if (dest > here) begin
            dir = DIR_EAST;
        end else begin
            dir = DIR_WEST;
        end
        return dir;
    endfunction

endpackage

// File: rtl/rx_input_port_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on dout while not empty.
// Pushes when full and pops when empty are ignored, so count stays within 0..DEPTH.
module fwft_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_input_port.sv
// Router input stage: pops flits from dclk_rx, tags each with its output direction and
// buffers {dir, flit} in a FWFT FIFO that the switch drains with valid/ready.
module rx_input_port
    import rx_input_port_pkg::*;
#(
    parameter logic [ADDR_SZ-1:0] ROUTER_ID = '0,
    parameter int                 DEPTH     = 4,
    parameter int                 PTR_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [FLIT_W-1:0] parallel_out,
    output logic              item_read,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_data,
    output logic [DIR_W-1:0]  out_dir,
    input  logic              out_ready,
    output logic [PTR_W:0]    occupancy,
    output logic [1:0]        intake_state
);

    // Handshake to the switch: the head flit leaves on any rising edge where
    // out_valid && out_ready; out_ready while empty has no effect.

    intake_state_t             state;
    intake_state_t             state_next;
    logic                      push;
    logic                      full;
    logic                      empty;
    logic [ADDR_SZ-1:0]        dest;
    logic [DIR_W-1:0]          dir;
    logic [DIR_W+FLIT_W-1:0]   head;

    assign dest         = parallel_out[FLIT_W-1 -: ADDR_SZ];
    assign dir          = route(dest, ROUTER_ID);
    assign intake_state = state;

    // Full is the pre-edge count, so a same-edge pop never admits this write.
    assign push = (state == ST_IDLE) && valid && !full;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (push) state_next = ST_ACK;
            ST_ACK:   state_next = ST_DRAIN;
            ST_DRAIN: if (!valid) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // item_read gets its own flop so the pop pulse to dclk_rx is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            item_read <= 1'b0;
        end else begin
            state     <= state_next;
            item_read <= (state_next == ST_ACK);
        end
    end

    fwft_fifo #(
        .WIDTH (DIR_W + FLIT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({dir, parallel_out}),
        .pop   (out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    assign out_valid = !empty;
    assign out_data  = head[FLIT_W-1:0];
    assign out_dir   = head[DIR_W+FLIT_W-1:FLIT_W];

endmodule

// File: doc/rx_input_port.md
Name: rx_input_port

Overview:
Router input stage directly downstream of dclk_rx.
- Pops flits from the receiver with the valid/item_read handshake and buffers them in a small first-word-fall-through FIFO.
- Computes each flit's output direction from its destination address and presents flit plus direction to the switch with a valid/ready handshake.
- One instance per router input link (west, east).

Parameters:
ROUTER_ID, 0, this router's address; same width as the `ADDR_SZ field.
DEPTH, 4, FIFO entries; power of two, 2..16.
PTR_W, 2, log2(DEPTH); must equal log2(DEPTH).

Ports:
clk  input  1  single clock; shared with the dclk_rx read side (its rclk).
reset  input  1  asynchronous, active-low (asserted when 0); clears all state immediately.
valid  input  1  dclk_rx holds a flit on parallel_out (level).
parallel_out  input  `PAYLOAD_SIZE+`ADDR_SZ  flit from dclk_rx; destination = top `ADDR_SZ bits, payload = low `PAYLOAD_SIZE bits.
item_read  output  1  one-cycle pop pulse to dclk_rx.
out_valid  output  1  head flit available.
out_data  output  `PAYLOAD_SIZE+`ADDR_SZ  head flit.
out_dir  output  3  one-hot route of head flit: 001 local, 010 east, 100 west.
out_ready  input  1  switch consumes head flit on an edge where out_valid && out_ready.
occupancy  output  PTR_W+1  number of flits stored.

Behaviour:
- Reset values: item_read=0, out_valid=0, out_data=0, out_dir=0, occupancy=0. Pointers are 0 and the intake FSM is in IDLE.
- Intake FSM, states IDLE, ACK, DRAIN; item_read is a registered output.
  - IDLE: if valid && occupancy<DEPTH, write parallel_out and its route into the FIFO on this edge and go to ACK. Otherwise stay in IDLE.
  - ACK: item_read=1 for exactly one cycle, then go to DRAIN.
  - DRAIN: item_read=0; stay until valid==0, then go to IDLE.
  - Consequence: exactly one write and one item_read pulse per flit, even if valid deasserts late.
- Full: a write is allowed only if occupancy<DEPTH, sampled before any same-cycle pop. A pop on the same edge does not admit a write; IDLE simply retries the next cycle.
- Route computation happens at write time, from dest = parallel_out[W-1 -: `ADDR_SZ]:
  - dest==ROUTER_ID gives 001.
  - dest>ROUTER_ID (unsigned) gives 010.
  - Otherwise 100.
  - The route is stored alongside the flit. out_dir is never 000 while out_valid=1.
- FWFT output: out_valid=(occupancy!=0). out_data and out_dir show the entry at the read pointer combinationally from storage.
  - Latency: a flit written on edge t into an empty FIFO is visible with out_valid=1 after edge t, i.e. in cycle t+1.
- Pop: out_valid && out_ready advances the read pointer. out_ready while empty is ignored.
- Simultaneous push and pop with the FIFO non-empty: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH and never overflows or underflows.
- out_data and out_dir are don't-care when out_valid=0. They hold the last head value; the bench must not check them.
- Reset asserted mid-operation:
  - Stored flits are discarded and item_read drops immediately.
  - A flit that dclk_rx is holding is re-read after reset release, which is acceptable because both blocks reset together.
- Throughput: at most one flit per 3 cycles, bounded by the valid fall time of dclk_rx.

Decomposition:
- Shared constants in constants.v: `PAYLOAD_SIZE and `ADDR_SZ (existing). Add `DIR_LOCAL=3'b001, `DIR_EAST=3'b010, `DIR_WEST=3'b100.
- One sub-module, fwft_fifo: parameterised on WIDTH and DEPTH, with push, pop, data in/out, full, empty and count. It stores {dir, flit}.
- Intake FSM and route compare stay in rx_input_port.

Test Plan:
(Bench settings: ROUTER_ID=2, `ADDR_SZ=4, `PAYLOAD_SIZE=8, DEPTH=4; dclk_rx is replaced by a behavioural model that drops valid 2 cycles after item_read.)
1. Reset low for 4 cycles, then release -> item_read, out_valid, out_dir = 0 and occupancy=0 during and after reset.
2. Present 12'h255 with out_ready=0 -> exactly one item_read pulse; out_valid=1 one cycle after the write edge; out_data=12'h255, out_dir=001, occupancy=1.
3. Present 12'h3A1 then 12'h0C4 with out_ready=1 -> out_dir 010 then 100; data delivered in order; occupancy returns to 0.
4. Present 5 flits with out_ready=0 -> 4 item_read pulses; occupancy=4 and valid stays high. After a single out_ready pulse the 5th flit is accepted, occupancy returns to 4, and order is preserved across pointer wrap.
5. Hold valid high for 6 cycles after item_read -> FSM stays in DRAIN; no second pulse or write; occupancy is incremented exactly once.
6. Assert reset during ACK with occupancy=2 -> item_read falls immediately; occupancy=0 and out_valid=0 with no clock edge required.
